// File: rtl/alu_dispatch.sv
// ALU request dispatcher: latches one request, drives the execution units for a per-op latency,
// captures the returned result and holds it until writeback accepts. Optional macro ALU_DISPATCH_ZFLAG_EN adds out_zero.
module alu_dispatch #(
  parameter int N       = 16,
  parameter int MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [3:0]   op_code,
  output logic [N-1:0] opa,
  output logic [N-1:0] opb,
  input  logic [N-1:0] result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_err
`ifdef ALU_DISPATCH_ZFLAG_EN
  ,
  output logic         out_zero
`endif
);

  localparam logic [3:0] OP_IDLE = 4'b1111;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_MAX  = 4'b0100;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   op_code_q, op_code_d;
  logic [N-1:0] opa_q, opa_d;
  logic [N-1:0] opb_q, opb_d;
  logic [N-1:0] out_data_q, out_data_d;
  logic         out_err_q, out_err_d;
`ifdef ALU_DISPATCH_ZFLAG_EN
  logic         out_zero_q, out_zero_d;
`endif

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path leaves a signal unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_code_d  = op_code_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
`ifdef ALU_DISPATCH_ZFLAG_EN
    out_zero_d = out_zero_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opa_d = in_a;
          opb_d = in_b;
          if (in_op <= OP_MAX) begin
            op_code_d = in_op;
            cnt_d     = (in_op == OP_MUL) ? MUL_CNT : 4'd1;
            state_d   = S_EXEC;
          end else begin
            // Illegal opcode: report straight away, the execution units never see it.
            out_data_d = '0;
            out_err_d  = 1'b1;
`ifdef ALU_DISPATCH_ZFLAG_EN
            out_zero_d = 1'b0;
`endif
            state_d    = S_DONE;
          end
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          out_data_d = result;
          out_err_d  = 1'b0;
`ifdef ALU_DISPATCH_ZFLAG_EN
          out_zero_d = (result == '0);
`endif
          op_code_d  = OP_IDLE;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_code_q  <= OP_IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
`ifdef ALU_DISPATCH_ZFLAG_EN
      out_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_code_q  <= op_code_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
`ifdef ALU_DISPATCH_ZFLAG_EN
      out_zero_q <= out_zero_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign op_code   = op_code_q;
  assign opa       = opa_q;
  assign opb       = opb_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
`ifdef ALU_DISPATCH_ZFLAG_EN
  assign out_zero  = out_zero_q;
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized self-checking bench for alu_dispatch; models the execution units and checks each
// transaction against a request-level reference (result, error, latency, handshake).
module tb_alu_dispatch;
  localparam int N       = 16;
  localparam int MUL_LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [N-1:0] in_a, in_b;
  logic [3:0]   op_code;
  logic [N-1:0] opa, opb;
  logic [N-1:0] result;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_err;
`ifdef ALU_DISPATCH_ZFLAG_EN
  logic         out_zero;
`endif

  int n_chk = 0;
  int n_err = 0;

  alu_dispatch #(.N(N), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .op_code(op_code), .opa(opa), .opb(opb), .result(result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
`ifdef ALU_DISPATCH_ZFLAG_EN
    , .out_zero(out_zero)
`endif
  );

  always #5 clk = ~clk;

  // Reference behaviour of the execution units for each legal opcode; idle code yields 0.
  function automatic logic [N-1:0] ref_exec(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a * b;
      4'd3:    r = a ^ b;
      4'd4:    r = {{(N-1){1'b0}}, (a < b)};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb result = ref_exec(op_code, opa, opb);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with bp cycles of writeback backpressure; a competing request is
  // presented during backpressure and across the handshake edge and must be ignored.
  task automatic do_req(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input int bp);
    bit           legal;
    int           exp_lat, lat, hold, waitc;
    bit           busy_bad;
    logic [N-1:0] exp_d;
    legal   = (op <= 4'd4);
    exp_lat = !legal ? 0 : (op == 4'd2 ? MUL_LAT : 1);
    exp_d   = legal ? ref_exec(op, a, b) : '0;
    waitc = 0;
    while (!in_ready && waitc < 20) begin step(); waitc++; end
    check("ready_before_req", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    step();
    in_valid = 1'b0; in_a = N'($urandom); in_b = N'($urandom); in_op = 4'(op + 4'd1);
    check("opa_latched", 32'(opa), 32'(a));
    check("opb_latched", 32'(opb), 32'(b));
    lat = 0; hold = 0; busy_bad = 0;
    while (!out_valid && lat < 40) begin
      if (op_code == op) hold++;
      if (in_ready) busy_bad = 1;
      step();
      lat++;
    end
    check("latency", lat, exp_lat);
    check("op_code_hold", hold, exp_lat);
    check("ready_low_busy", 32'(busy_bad), 32'd0);
    check("op_code_idle_done", 32'(op_code), 32'hF);
    check("out_data", 32'(out_data), 32'(exp_d));
    check("out_err", 32'(out_err), 32'(!legal));
`ifdef ALU_DISPATCH_ZFLAG_EN
    check("out_zero", 32'(out_zero), 32'(legal && exp_d == '0));
`endif
    out_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1; in_op = 4'd0;
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data_stable", 32'(out_data), 32'(exp_d));
      check("bp_no_latch", 32'(opa), 32'(a));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_ready", 32'(in_ready), 32'd1);
    check("post_hs_no_latch", 32'(opa), 32'(a));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_op_code", 32'(op_code), 32'hF);
    check("rst_opa", 32'(opa), 32'd0);
    check("rst_opb", 32'(opb), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);

    do_req(4'd0, 16'd5, 16'd7, 0);
    do_req(4'd2, 16'd3, 16'd4, 1);
    do_req(4'd7, 16'h1234, 16'h5678, 0);
    do_req(4'd1, 16'd100, 16'd33, 4);
    do_req(4'd15, 16'hFFFF, 16'd1, 2);
    do_req(4'd4, 16'd2, 16'd9, 0);

    // Reset in the second multiply EXEC cycle discards the transaction.
    in_valid = 1'b1; in_op = 4'd2; in_a = 16'd11; in_b = 16'd13;
    step();
    in_valid = 1'b0;
    step();
    check("mul_exec2_op", 32'(op_code), 32'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_op_code", 32'(op_code), 32'hF);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_out_data", 32'(out_data), 32'd0);
    do_req(4'd0, 16'd20, 16'd22, 0);

    // Reset wins over a simultaneous accept.
    rst = 1'b1; in_valid = 1'b1; in_op = 4'd0; in_a = 16'hAAAA; in_b = 16'h5555;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rstpri_ready", 32'(in_ready), 32'd1);
    check("rstpri_opa", 32'(opa), 32'd0);
    check("rstpri_op_code", 32'(op_code), 32'hF);

`ifdef ALU_DISPATCH_ZFLAG_EN
    do_req(4'd1, 16'd9, 16'd9, 0);
    do_req(4'd0, 16'd1, 16'd1, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      logic [3:0] rop;
      rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      do_req(rop, N'($urandom), N'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
